// File: rtl/psum_post_proc_if.sv
// Partial-sum input stream and requantized activation output stream of psum_post_proc.
// slave = post-processor side, master = MAC array / feature-map writer side.
interface psum_post_proc_if #(
    parameter int NF     = 40,
    parameter int PSUM_W = 22,
    parameter int OUT_W  = 8
);
    logic [NF*PSUM_W-1:0] psum_i;
    logic                 vld_i;
    logic                 in_rdy_o;
    logic [OUT_W-1:0]     out_data_o;
    logic [5:0]           out_idx_o;
    logic                 out_vld_o;
    logic                 out_rdy_i;
    logic                 out_last_o;

    modport slave (
        input  psum_i, vld_i, out_rdy_i,
        output in_rdy_o, out_data_o, out_idx_o, out_vld_o, out_last_o
    );

    modport master (
        output psum_i, vld_i, out_rdy_i,
        input  in_rdy_o, out_data_o, out_idx_o, out_vld_o, out_last_o
    );
endinterface

// File: rtl/psum_post_proc.sv
// Accumulates NF partial-sum lanes over several passes, adds bias, then drains ReLU/shift/saturated
// results one lane per cycle. Define PSUM_ROUND_EN to round half up before the shift instead of flooring.
module psum_post_proc #(
    parameter int NF     = 40,
    parameter int PSUM_W = 22,
    parameter int ACC_W  = 32,
    parameter int BIAS_W = 16,
    parameter int OUT_W  = 8,
    parameter int PASS_W = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [PASS_W-1:0]    cfg_num_pass,
    input  logic [4:0]           cfg_shift,
    input  logic                 cfg_relu_en,
    input  logic [NF*BIAS_W-1:0] bias_i,
    psum_post_proc_if.slave      s_if,
    output logic                 err_o
);
    typedef enum logic {ACCUM, DRAIN} state_e;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

    state_e                  state_q, state_d;
    logic [PASS_W-1:0]       pass_cnt_q, pass_cnt_d;
    logic signed [ACC_W-1:0] acc_q [NF];
    logic signed [ACC_W-1:0] acc_d [NF];
    logic [4:0]              shift_q, shift_d;
    logic                    relu_q, relu_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic [5:0]              out_idx_q, out_idx_d;
    logic                    out_vld_q, out_vld_d;
    logic                    err_q, err_d;

    logic                    in_rdy, accept, final_pass, fire, at_last;
    logic [PASS_W:0]         pass_num, pass_tgt;
    logic [5:0]              idx_nxt;

    // One extra bit of headroom so the rounding increment cannot overflow.
    function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                                 input logic [4:0] sh, input logic relu);
        logic signed [ACC_W:0] v;
        logic signed [ACC_W:0] r;
        v = (ACC_W+1)'(acc);
        if (relu && v[ACC_W]) v = '0;
`ifdef PSUM_ROUND_EN
        if (sh != 5'd0) v = v + ((ACC_W+1)'(1) << (sh - 5'd1));
`endif
        r = v >>> sh;
        if (r > SAT_MAX)      requant = OUT_W'(SAT_MAX);
        else if (r < SAT_MIN) requant = OUT_W'(SAT_MIN);
        else                  requant = OUT_W'(r);
    endfunction

    always_comb begin
        pass_num   = {1'b0, pass_cnt_q} + (PASS_W+1)'(1);
        pass_tgt   = (cfg_num_pass == '0) ? (PASS_W+1)'(1) : {1'b0, cfg_num_pass};
        accept     = s_if.vld_i && in_rdy;
        final_pass = accept && (pass_num == pass_tgt);
        fire       = out_vld_q && s_if.out_rdy_i;
        at_last    = (out_idx_q == 6'(NF - 1));
        idx_nxt    = out_idx_q + 6'd1;
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= ACCUM;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (final_pass)      state_d = DRAIN;
            DRAIN:   if (fire && at_last) state_d = ACCUM;
            default:                      state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_rdy          = (state_q == ACCUM);
        s_if.in_rdy_o   = in_rdy;
        s_if.out_data_o = out_data_q;
        s_if.out_idx_o  = out_idx_q;
        s_if.out_vld_o  = out_vld_q;
        s_if.out_last_o = out_vld_q && at_last;
        err_o           = err_q;
    end

    // NOTE: every always_comb output takes its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        acc_d      = acc_q;
        pass_cnt_d = pass_cnt_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_vld_d  = out_vld_q;
        err_d      = err_q | (s_if.vld_i && !in_rdy);

        if (accept) begin
            for (int k = 0; k < NF; k++) begin
                if (pass_cnt_q == '0)
                    acc_d[k] = ACC_W'($signed(s_if.psum_i[k*PSUM_W +: PSUM_W]))
                             + ACC_W'($signed(bias_i[k*BIAS_W +: BIAS_W]));
                else
                    acc_d[k] = acc_q[k] + ACC_W'($signed(s_if.psum_i[k*PSUM_W +: PSUM_W]));
            end
            pass_cnt_d = pass_num[PASS_W-1:0];
            if (final_pass) begin
                pass_cnt_d = '0;
                shift_d    = cfg_shift;
                relu_d     = cfg_relu_en;
                out_vld_d  = 1'b1;
                out_idx_d  = 6'd0;
                out_data_d = requant(acc_d[0], cfg_shift, cfg_relu_en);
            end
        end

        if (fire) begin
            if (at_last) begin
                out_vld_d = 1'b0;
                out_idx_d = 6'd0;
            end else begin
                out_idx_d  = idx_nxt;
                out_data_d = requant(acc_q[idx_nxt], shift_q, relu_q);
            end
        end
    end

    // NOTE: the accumulator array is reset on purpose, since it is required to read as zero after reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NF; k++) acc_q[k] <= '0;
            pass_cnt_q <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_vld_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            pass_cnt_q <= pass_cnt_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            out_vld_q  <= out_vld_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_psum_post_proc.sv
// Bench for psum_post_proc: queue-based reference model plus directed and randomized frames.
// Build with +define+PSUM_ROUND_EN to check the rounding variant.
module tb_psum_post_proc;
    localparam int NF     = 40;
    localparam int PSUM_W = 22;
    localparam int BIAS_W = 16;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [7:0]           cfg_num_pass;
    logic [4:0]           cfg_shift;
    logic                 cfg_relu_en;
    logic [NF*BIAS_W-1:0] bias_i;
    logic                 err_o;

    psum_post_proc_if #(.NF(NF), .PSUM_W(PSUM_W), .OUT_W(8)) bus ();

    psum_post_proc dut (
        .clk          (clk),
        .rstn         (rstn),
        .cfg_num_pass (cfg_num_pass),
        .cfg_shift    (cfg_shift),
        .cfg_relu_en  (cfg_relu_en),
        .bias_i       (bias_i),
        .s_if         (bus.slave),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_fail = 0;
    bit   done   = 0;
    bit   rand_rdy = 0;
    int   psum_v [NF];
    int   bias_v [NF];

    int   m_acc [NF];
    int   m_pass = 0;
    bit   m_rdy  = 1;
    bit   m_err  = 0;
    exp_t m_q [$];

    task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Specification arithmetic: optional ReLU, optional round-half-up, arithmetic shift, clamp to int8.
    function automatic int requant(input int acc, input int sh, input bit relu);
        longint v;
        longint r;
        v = acc;
        if (relu && v < 0) v = 0;
`ifdef PSUM_ROUND_EN
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
        r = v >>> sh;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    // Reference model: frames accumulate on accepted vld_i, then their NF results wait in a queue.
    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) begin
                m_q.delete();
                m_pass = 0;
                m_rdy  = 1;
                m_err  = 0;
                foreach (m_acc[k]) m_acc[k] = 0;
            end else begin
                bit rdy_now;
                rdy_now = m_rdy;
                if (m_q.size() > 0 && bus.out_rdy_i) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_rdy = 1;
                end
                if (bus.vld_i) begin
                    if (!rdy_now) m_err = 1;
                    else begin
                        int tgt;
                        for (int k = 0; k < NF; k++) begin
                            logic signed [PSUM_W-1:0] p;
                            logic signed [BIAS_W-1:0] b;
                            p = bus.psum_i[k*PSUM_W +: PSUM_W];
                            b = bias_i[k*BIAS_W +: BIAS_W];
                            m_acc[k] = (m_pass == 0) ? int'(p) + int'(b) : m_acc[k] + int'(p);
                        end
                        m_pass++;
                        tgt = (cfg_num_pass == 0) ? 1 : int'(cfg_num_pass);
                        if (m_pass == tgt) begin
                            m_pass = 0;
                            m_rdy  = 0;
                            for (int k = 0; k < NF; k++)
                                m_q.push_back('{idx: k, data: requant(m_acc[k], int'(cfg_shift), cfg_relu_en)});
                        end
                    end
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!done) begin
                check("out_vld", bus.out_vld_o, m_q.size() != 0);
                check("in_rdy", bus.in_rdy_o, m_rdy);
                check("err", err_o, m_err);
                if (m_q.size() != 0) begin
                    check("out_idx", bus.out_idx_o, m_q[0].idx);
                    check("out_data", $signed(bus.out_data_o), m_q[0].data);
                    check("out_last", bus.out_last_o, m_q[0].idx == NF - 1);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_rdy_i = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bias();
        for (int k = 0; k < NF; k++) bias_i[k*BIAS_W +: BIAS_W] = BIAS_W'(bias_v[k]);
    endtask

    task automatic drive_psum();
        for (int k = 0; k < NF; k++) bus.psum_i[k*PSUM_W +: PSUM_W] = PSUM_W'(psum_v[k]);
    endtask

    task automatic rand_lanes();
        for (int k = 0; k < NF; k++) begin
            psum_v[k] = int'($urandom);
            bias_v[k] = int'($urandom);
        end
    endtask

    task automatic wait_rdy(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (bus.in_rdy_o) return;
            tick();
        end
        check(name, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (bus.in_rdy_o && !bus.out_vld_o) return;
            tick();
        end
        check(name, 0, 1);
    endtask

    task automatic wait_out_idx(input int idx, input string name);
        for (int i = 0; i < 3000; i++) begin
            if (bus.out_vld_o && bus.out_idx_o == 6'(idx)) return;
            tick();
        end
        check(name, 0, 1);
    endtask

    task automatic send_pass();
        wait_rdy("timeout_in_rdy");
        drive_psum();
        bus.vld_i = 1'b1;
        tick();
        bus.vld_i = 1'b0;
    endtask

    task automatic set_cfg(input int npass, input int sh, input bit relu);
        cfg_num_pass = 8'(npass);
        cfg_shift    = 5'(sh);
        cfg_relu_en  = relu;
    endtask

    task automatic single_lane0(input int p0, input int sh, input bit relu, input int exp, input string name);
        set_cfg(1, sh, relu);
        for (int k = 0; k < NF; k++) begin
            bias_v[k] = 0;
            psum_v[k] = k * 3;
        end
        psum_v[0] = p0;
        drive_bias();
        send_pass();
        check(name, $signed(bus.out_data_o), exp);
        wait_idle("timeout_idle");
    endtask

    initial begin
        rstn = 1'b0;
        bus.vld_i = 1'b0;
        bus.out_rdy_i = 1'b1;
        bus.psum_i = '0;
        bias_i = '0;
        set_cfg(1, 0, 0);
        tick();
        tick();
        check("rst_out_vld", bus.out_vld_o, 0);
        check("rst_out_data", bus.out_data_o, 0);
        check("rst_out_idx", bus.out_idx_o, 0);
        check("rst_out_last", bus.out_last_o, 0);
        check("rst_in_rdy", bus.in_rdy_o, 1);
        check("rst_err", err_o, 0);
        rstn = 1'b1;

        check("model_pin_floor", requant(605, 4, 0),
`ifdef PSUM_ROUND_EN
              38);
`else
              37);
`endif
        check("model_pin_relu", requant(-1000, 0, 1), 0);

        // Single pass, lane k = k-20, no bias/shift: one result per cycle, one cycle latency.
        set_cfg(1, 0, 0);
        for (int k = 0; k < NF; k++) begin
            bias_v[k] = 0;
            psum_v[k] = k - 20;
        end
        drive_bias();
        send_pass();
        check("tp1_first_vld", bus.out_vld_o, 1);
        check("tp1_first_idx", bus.out_idx_o, 0);
        check("tp1_first_data", $signed(bus.out_data_o), -20);
        for (int k = 1; k < NF; k++) begin
            tick();
            check("tp1_idx", bus.out_idx_o, k);
            check("tp1_data", $signed(bus.out_data_o), k - 20);
            check("tp1_last", bus.out_last_o, k == NF - 1);
        end
        tick();
        check("tp1_done_vld", bus.out_vld_o, 0);
        check("tp1_done_rdy", bus.in_rdy_o, 1);

        // Three passes with bias on lane 0: 5 + 100 + 200 + 300 = 605, shift 4.
        rand_lanes();
        set_cfg(3, 4, 0);
        bias_v[0] = 5;
        drive_bias();
        psum_v[0] = 100;
        send_pass();
        for (int k = 0; k < NF; k++) psum_v[k] = int'($urandom);
        psum_v[0] = 200;
        send_pass();
        for (int k = 0; k < NF; k++) psum_v[k] = int'($urandom);
        psum_v[0] = 300;
        send_pass();
`ifdef PSUM_ROUND_EN
        check("tp2_lane0", $signed(bus.out_data_o), 38);
`else
        check("tp2_lane0", $signed(bus.out_data_o), 37);
`endif
        wait_idle("timeout_idle");

        // Saturation and ReLU corners.
        single_lane0(-1000, 0, 0, -128, "tp3_neg_sat");
        single_lane0(-1000, 0, 1, 0, "tp3_relu");
        single_lane0(5000, 2, 0, 127, "tp3_pos_sat");

        // Backpressure at idx 3 plus a stray vld_i during DRAIN.
        rand_lanes();
        set_cfg(2, 3, 0);
        drive_bias();
        send_pass();
        send_pass();
        wait_out_idx(3, "timeout_idx3");
        bus.out_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                for (int k = 0; k < NF; k++) psum_v[k] = int'($urandom);
                drive_psum();
                bus.vld_i = 1'b1;
            end
            tick();
            bus.vld_i = 1'b0;
            check("bp_idx_hold", bus.out_idx_o, 3);
        end
        bus.out_rdy_i = 1'b1;
        tick();
        check("bp_idx_next", bus.out_idx_o, 4);
        check("bp_err_sticky", err_o, 1);
        wait_idle("timeout_idle");
        rand_lanes();
        set_cfg(1, 1, 1);
        drive_bias();
        send_pass();
        wait_idle("timeout_idle");

        // Reset in the middle of DRAIN at idx 10.
        rand_lanes();
        set_cfg(1, 2, 0);
        drive_bias();
        send_pass();
        wait_out_idx(10, "timeout_idx10");
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mid_rst_vld", bus.out_vld_o, 0);
        check("mid_rst_rdy", bus.in_rdy_o, 1);
        check("mid_rst_err", err_o, 0);
        rand_lanes();
        set_cfg(1, 0, 0);
        drive_bias();
        send_pass();
        check("post_rst_idx", bus.out_idx_o, 0);
        wait_idle("timeout_idle");

        // Pass count 0 behaves as 1.
        rand_lanes();
        set_cfg(0, 5, 0);
        drive_bias();
        send_pass();
        check("np0_vld", bus.out_vld_o, 1);
        wait_idle("timeout_idle");

        // Randomized frames with random backpressure.
        rand_rdy = 1;
        for (int f = 0; f < 24; f++) begin
            int np;
            np = $urandom_range(0, 4);
            rand_lanes();
            set_cfg(np, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 14),
                    $urandom_range(0, 1) != 0);
            drive_bias();
            for (int p = 0; p < ((np == 0) ? 1 : np); p++) begin
                for (int k = 0; k < NF; k++) psum_v[k] = int'($urandom);
                send_pass();
            end
        end
        rand_rdy = 0;
        tick();
        bus.out_rdy_i = 1'b1;
        wait_idle("timeout_idle");
        tick();
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/psum_post_proc.md
Name: psum_post_proc

Overview:
- Downstream stage of the 40-filter MAC array.
- Accumulates the per-filter 22-bit partial sums over multiple input-channel passes and adds a per-filter bias once.
- Then applies optional ReLU, arithmetic right-shift requantization and 8-bit saturation.
- Drains results one filter per cycle over a valid/ready stream toward the output feature-map writer.

Parameters:
NF, 40, number of filter lanes (one per MAC partial sum)
PSUM_W, 22, partial-sum width from the MAC array (signed)
ACC_W, 32, accumulator width per lane (signed)
BIAS_W, 16, bias width per lane (signed)
OUT_W, 8, output activation width (signed)
PASS_W, 8, width of the pass-count configuration

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
cfg_num_pass  in  PASS_W  channel-group passes per output pixel; 0 treated as 1
cfg_shift  in  5  requantization right-shift amount
cfg_relu_en  in  1  1 = clamp negative results to 0
bias_i  in  NF*BIAS_W  lane k bias at [k*BIAS_W +: BIAS_W]
psum_i  in  NF*PSUM_W  lane k partial sum at [k*PSUM_W +: PSUM_W]; lane 0 = MAC sum1
vld_i  in  1  all NF partial sums valid (AND of MAC vld_o1..vld_o40)
in_rdy_o  out  1  block accepting partial sums
out_data_o  out  OUT_W  requantized activation
out_idx_o  out  6  filter index of out_data_o (0..NF-1)
out_vld_o  out  1  output valid
out_rdy_i  in  1  downstream ready
out_last_o  out  1  high with out_idx_o == NF-1
err_o  out  1  sticky: vld_i received while in_rdy_o = 0

Behaviour:
- Reset state (rstn low at clk edge):
  - FSM in ACCUM; pass_cnt = 0; all acc = 0.
  - out_vld_o = 0, out_data_o = 0, out_idx_o = 0, out_last_o = 0.
  - in_rdy_o = 1, err_o = 0.
- ACCUM state (in_rdy_o = 1), on vld_i:
  - pass_cnt == 0: acc[k] = sext(psum[k]) + sext(bias[k]).
  - Otherwise: acc[k] += sext(psum[k]).
  - Accumulator wraps two's complement; no saturation. ACC_W covers 256 passes.
  - pass_cnt increments.
- ACCUM exit: when the accepted vld_i is pass number max(cfg_num_pass,1):
  - pass_cnt clears; FSM goes to DRAIN.
  - cfg_shift and cfg_relu_en are latched.
  - Lane 0 result is registered onto the output.
- Latency: final vld_i at edge T gives out_vld_o = 1, out_idx_o = 0 after edge T.
- Per-lane output function:
  - v = acc[k].
  - If relu and v < 0, v = 0.
  - r = v >>> shift.
  - Saturate r to [-128, 127].
- DRAIN state (in_rdy_o = 0):
  - Outputs hold while out_vld_o && !out_rdy_i.
  - On handshake at index i < NF-1: the next lane result is registered; no bubble.
  - On handshake with out_last_o: out_vld_o = 0 and FSM returns to ACCUM, in_rdy_o = 1 next cycle.
- vld_i while in_rdy_o = 0: the data is dropped, acc is unchanged, err_o is set and held until reset.
- Config stability:
  - cfg_num_pass and bias_i must be stable while pass_cnt != 0.
  - cfg_shift and cfg_relu_en are don't-care after the DRAIN latch.
- Reset mid-operation (any state): everything returns to the reset state on that edge; partial accumulators are discarded.

Optional Feature:
- Macro: PSUM_ROUND_EN.
- Defined: before the shift, add 1 << (shift-1) when shift > 0 (round half up). ReLU applies before rounding.
- Undefined: plain arithmetic shift (floor).

Test Plan:
- num_pass=1, shift=0, relu=0, bias=0, psum lane k = k-20, out_rdy_i=1 -> out_vld_o rises 1 cycle after vld_i; idx 0..39 carry data -20..19 on consecutive cycles; out_last_o on idx 39; in_rdy_o = 1 the cycle after.
- num_pass=3, lane 0 psums 100,200,300, bias 5, shift=4 -> lane 0 = 37 (605>>>4); with PSUM_ROUND_EN = 38.
- shift=0: psum -1000 with relu=0 -> -128, with relu=1 -> 0; psum 5000 with shift=2 -> 127 (saturated from 1250).
- out_rdy_i low 5 cycles while idx=3 -> out_data_o and out_idx_o stable, no skip; vld_i pulse during DRAIN -> err_o = 1 and stays 1, acc unchanged, later results correct.
- rstn low 1 cycle during DRAIN at idx 10 -> next cycle out_vld_o = 0, in_rdy_o = 1, err_o = 0; a following single-pass frame produces correct output from idx 0.
- cfg_num_pass=0 -> behaves as 1: DRAIN begins after the first vld_i.
